// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: d = a - b over WIDTH bits, one bit per clock, LSB first.
// Optional signed-overflow flag enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             borrow,
    output logic             ovf
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_sh, a_sh_nx;
    logic [WIDTH-1:0] b_sh, b_sh_nx;
    logic [WIDTH-1:0] res_sh, res_sh_nx;
    logic [WIDTH-1:0] d_q, d_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             br, br_nx;
    logic             borrow_q, borrow_nx;

    // Half-subtractor cell with the registered borrow folded in.
    logic a0, b0, diff_bit, br_calc, last_bit;

    assign a0       = a_sh[0];
    assign b0       = b_sh[0];
    assign diff_bit = a0 ^ b0 ^ br;
    assign br_calc  = (~a0 & b0) | (~(a0 ^ b0) & br);
    assign last_bit = (cnt == LAST);

    // Handshake: start is accepted only in IDLE or DONE (busy=0); a/b are
    // captured on that edge. busy is high for exactly WIDTH cycles, then done
    // pulses for one cycle with d/borrow/ovf already valid; those outputs hold
    // until the next operation completes. start while busy is ignored.
    always_comb begin
        state_nx  = state;
        a_sh_nx   = a_sh;
        b_sh_nx   = b_sh;
        res_sh_nx = res_sh;
        cnt_nx    = cnt;
        br_nx     = br;
        d_nx      = d_q;
        borrow_nx = borrow_q;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx  = SHIFT;
                    a_sh_nx   = a;
                    b_sh_nx   = b;
                    res_sh_nx = '0;
                    cnt_nx    = '0;
                    br_nx     = 1'b0;
                end
            end
            SHIFT: begin
                a_sh_nx   = a_sh >> 1;
                b_sh_nx   = b_sh >> 1;
                res_sh_nx = {diff_bit, res_sh[WIDTH-1:1]};
                br_nx     = br_calc;
                cnt_nx    = cnt + CNT_W'(1);
                if (last_bit) begin
                    state_nx  = DONE;
                    d_nx      = {diff_bit, res_sh[WIDTH-1:1]};
                    borrow_nx = br_calc;
                end
            end
            DONE: begin
                state_nx = IDLE;
                if (start) begin
                    state_nx  = SHIFT;
                    a_sh_nx   = a;
                    b_sh_nx   = b;
                    res_sh_nx = '0;
                    cnt_nx    = '0;
                    br_nx     = 1'b0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            a_sh     <= '0;
            b_sh     <= '0;
            res_sh   <= '0;
            cnt      <= '0;
            br       <= 1'b0;
            d_q      <= '0;
            borrow_q <= 1'b0;
        end else begin
            state    <= state_nx;
            a_sh     <= a_sh_nx;
            b_sh     <= b_sh_nx;
            res_sh   <= res_sh_nx;
            cnt      <= cnt_nx;
            br       <= br_nx;
            d_q      <= d_nx;
            borrow_q <= borrow_nx;
        end
    end

    assign busy   = (state == SHIFT);
    assign done   = (state == DONE);
    assign d      = d_q;
    assign borrow = borrow_q;

`ifdef SERIAL_SUB_OVF_EN
    // On the last SHIFT cycle a0/b0 are the operand sign bits.
    logic ovf_q, ovf_nx;

    always_comb begin
        ovf_nx = ovf_q;
        if (state == SHIFT && last_bit)
            ovf_nx = (a0 ^ b0) & (diff_bit ^ a0);
    end

    always_ff @(posedge clk) begin
        if (reset) ovf_q <= 1'b0;
        else       ovf_q <= ovf_nx;
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule
